// File: rtl/io_cycle_master_pkg.sv
// Shared types for the synthetic Z80 I/O cycle master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package io_cycle_master_pkg;

  // One queued I/O command as seen by the FIFO and the cycle FSM.
  typedef struct packed {
    logic        wr;    // 1 = OUT, 0 = IN
    logic [15:0] addr;  // full 16-bit port address
    logic [7:0]  data;  // write data, don't care for reads
  } io_cmd_t;

  // Bus cycle phases.
  typedef enum logic [1:0] {
    IOM_IDLE   = 2'd0,
    IOM_SETUP  = 2'd1,
    IOM_ACTIVE = 2'd2,
    IOM_HOLD   = 2'd3
  } iom_state_t;

  // Value a Z80 reads from an unclaimed port (pulled-up data bus).
  localparam logic [7:0] FLOAT_BUS = 8'hFF;

  // Largest of three timing parameters, used to size the phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/io_cmd_fifo.sv
// Synchronous FIFO of io_cmd_t commands with flush.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: full blocks push; flush empties the queue and beats a same-cycle push.
module io_cmd_fifo
  import io_cycle_master_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk28,
  input  logic    rst_n,
  input  logic    push,
  input  io_cmd_t push_dat,
  input  logic    pop,
  input  logic    flush,
  output io_cmd_t head_dat,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  io_cmd_t          mem_q [DEPTH];
  io_cmd_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CNT_FULL);
  assign empty    = (cnt_q == '0);
  assign head_dat = mem_q[rd_ptr_q];

  // flush overrides both push and pop so nothing new survives a flush cycle
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      // drop everything by catching the read pointer up to the write pointer
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
        2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Register storage, pointers and occupancy.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/io_cycle_master.sv
// Replays queued commands as ordinary Z80 I/O cycles on the CPU-bus mux.
// Latency: ioreq 1+SETUP_CYC cycles after push to an idle queue; rsp_valid after 1+SETUP+ACTIVE+HOLD.
// Backpressure: cmd_ready = !full; bus_grant gates cycle start only; rsp_valid is never stalled.
module io_cycle_master
  import io_cycle_master_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2,
  parameter int ACTIVE_CYC = 8,
  parameter int HOLD_CYC   = 2
) (
  input  logic        rst_n,
  input  logic        clk28,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic        flush,
  input  logic        bus_grant,
  output logic        busy,
  output logic        ioreq,
  output logic        rd,
  output logic        wr,
  output logic [15:0] a_reg,
  output logic [7:0]  d_reg,
  input  logic [7:0]  d_in,
  input  logic        d_in_active,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_hit
);

  // One shared down-counter covers every phase, so size it for the longest one.
  localparam int MAX_CYC = max3(SETUP_CYC, ACTIVE_CYC, HOLD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LOAD = CNT_W'(ACTIVE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

  // ------------------------------------------------------------------
  // Command queue
  // ------------------------------------------------------------------
  io_cmd_t fifo_in;
  io_cmd_t fifo_head;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fifo_push;
  logic    fifo_pop;

  // ready is held low while reset is asserted so nothing looks acceptable
  assign cmd_ready = rst_n & ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready;
  assign fifo_in   = '{wr: cmd_wr, addr: cmd_addr, data: cmd_data};

  io_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk28    (clk28),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (fifo_in),
    .pop      (fifo_pop),
    .flush    (flush),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // ------------------------------------------------------------------
  // Cycle FSM, bus output registers and read capture
  // ------------------------------------------------------------------
  iom_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;          // 1 = write cycle
  logic [15:0]      a_q, a_d;
  logic [7:0]       d_q, d_d;
  logic             ioreq_q, ioreq_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [7:0]       cap_dat_q, cap_dat_d;
  logic             cap_hit_q, cap_hit_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic [7:0]       rsp_dat_q, rsp_dat_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic             start;

  // A flushed head must not start a cycle in the same clock it is dropped.
  assign start    = (state_q == IOM_IDLE) && !fifo_empty && bus_grant && !flush;
  assign fifo_pop = start;

  // Next-state and next-output computation for the whole bus cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    a_d       = a_q;
    d_d       = d_q;
    ioreq_d   = ioreq_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cap_dat_d = cap_dat_q;
    cap_hit_d = cap_hit_q;
    rsp_vld_d = 1'b0;
    rsp_dat_d = rsp_dat_q;
    rsp_hit_d = rsp_hit_q;

    case (state_q)
      IOM_IDLE: begin
        if (start) begin
          state_d = IOM_SETUP;
          cnt_d   = SETUP_LOAD;
          dir_d   = fifo_head.wr;
          a_d     = fifo_head.addr;
          d_d     = fifo_head.data;
        end
      end

      IOM_SETUP: begin
        if (cnt_q == '0) begin
          state_d = IOM_ACTIVE;
          cnt_d   = ACTIVE_LOAD;
          ioreq_d = 1'b1;
          rd_d    = ~dir_q;
          wr_d    = dir_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      IOM_ACTIVE: begin
        if (cnt_q == '0) begin
          // Sample as late as possible: responders decode one clock behind ioreq.
          if (!dir_q) begin
            cap_dat_d = d_in;
            cap_hit_d = d_in_active;
          end
          state_d = IOM_HOLD;
          cnt_d   = HOLD_LOAD;
          ioreq_d = 1'b0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      IOM_HOLD: begin
        if (cnt_q == '0) begin
          state_d   = IOM_IDLE;
          rsp_vld_d = 1'b1;
          if (dir_q) begin
            rsp_dat_d = d_q;
            rsp_hit_d = 1'b0;
          end else begin
            rsp_dat_d = cap_hit_q ? cap_dat_q : FLOAT_BUS;
            rsp_hit_d = cap_hit_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IOM_IDLE;
        ioreq_d = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // FSM state and all registered outputs; reset abandons any cycle in flight.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IOM_IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      a_q       <= '0;
      d_q       <= '0;
      ioreq_q   <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cap_dat_q <= '0;
      cap_hit_q <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= '0;
      rsp_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      a_q       <= a_d;
      d_q       <= d_d;
      ioreq_q   <= ioreq_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cap_dat_q <= cap_dat_d;
      cap_hit_q <= cap_hit_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_hit_q <= rsp_hit_d;
    end
  end

  assign busy      = (state_q != IOM_IDLE);
  assign ioreq     = ioreq_q;
  assign rd        = rd_q;
  assign wr        = wr_q;
  assign a_reg     = a_q;
  assign d_reg     = d_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_data  = rsp_dat_q;
  assign rsp_hit   = rsp_hit_q;

endmodule

// File: tb/tb_io_cycle_master.sv
// Bench for io_cycle_master with a small port-decoder model on the bus.
// Expected bus cycles and responses are queued at stimulus time and popped by monitors.
// Timing is sampled on the falling edge of clk28.
module tb_io_cycle_master;

  typedef struct packed {
    logic [7:0] data;
    logic       hit;
  } rsp_exp_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } bus_exp_t;

  logic        clk28 = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        flush, bus_grant, busy;
  logic        ioreq, rd, wr;
  logic [15:0] a_reg;
  logic [7:0]  d_reg;
  logic [7:0]  d_in;
  logic        d_in_active;
  logic        rsp_valid, rsp_hit;
  logic [7:0]  rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  rsp_exp_t rsp_q[$];
  bus_exp_t bus_q[$];

  always #5 clk28 = ~clk28;

  io_cycle_master #(
    .FIFO_DEPTH (4),
    .SETUP_CYC  (2),
    .ACTIVE_CYC (8),
    .HOLD_CYC   (2)
  ) dut (
    .rst_n       (rst_n),
    .clk28       (clk28),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .flush       (flush),
    .bus_grant   (bus_grant),
    .busy        (busy),
    .ioreq       (ioreq),
    .rd          (rd),
    .wr          (wr),
    .a_reg       (a_reg),
    .d_reg       (d_reg),
    .d_in        (d_in),
    .d_in_active (d_in_active),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_hit     (rsp_hit)
  );

  // Port decoder model: #7FFD paging latch, #FE keyboard/tape read (decode one clock late).
  logic [4:0] kd;
  logic       tape_in;
  logic [2:0] rampage;
  logic       screen, rom, dec_rd_q;

  always @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      rampage  <= 3'd0;
      screen   <= 1'b0;
      rom      <= 1'b0;
      dec_rd_q <= 1'b0;
    end else begin
      if (ioreq && wr && a_reg == 16'h7FFD) begin
        rampage <= d_reg[2:0];
        screen  <= d_reg[3];
        rom     <= d_reg[4];
      end
      dec_rd_q <= ioreq && rd && !a_reg[0];
    end
  end

  assign d_in        = dec_rd_q ? {1'b1, tape_in, 1'b1, kd} : 8'h00;
  assign d_in_active = dec_rd_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expected response.
  always @(negedge clk28) begin
    rsp_exp_t e;
    if (rst_n && rsp_valid) begin
      if (rsp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data 0x%0h hit %0d, expected no response", rsp_data, rsp_hit);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_hit", 32'(rsp_hit), 32'(e.hit));
      end
    end
  end

  // Bus monitor: each ioreq pulse must match the oldest expected cycle and last 8 clocks.
  int hi_len  = 0;
  bit prev_io = 1'b0;
  always @(negedge clk28) begin
    bus_exp_t b;
    if (!rst_n) begin
      hi_len  = 0;
      prev_io = 1'b0;
    end else begin
      if (ioreq) begin
        if (!prev_io) begin
          if (bus_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_bus_cycle: got addr 0x%0h wr %0d, expected none", a_reg, wr);
          end else begin
            b = bus_q.pop_front();
            check("bus_addr", 32'(a_reg), 32'(b.addr));
            check("bus_wr", 32'(wr), 32'(b.wr));
            check("bus_rd", 32'(rd), 32'(!b.wr));
            if (b.wr) check("bus_dout", 32'(d_reg), 32'(b.data));
          end
        end
        hi_len++;
      end else if (prev_io) begin
        check("ioreq_len", 32'(hi_len), 32'd8);
        hi_len = 0;
      end
      prev_io = ioreq;
    end
  end

  // Offer one command for a clock; queue what the bus and response side must later show.
  task automatic push(input logic w, input logic [15:0] a, input logic [7:0] d,
                      input bit exp_acc, input bit exp_bus, input bit exp_rsp,
                      input logic [7:0] rdat, input logic rhit);
    check("cmd_ready", 32'(cmd_ready), 32'(exp_acc));
    cmd_valid = 1'b1;
    cmd_wr    = w;
    cmd_addr  = a;
    cmd_data  = d;
    if (exp_bus) bus_q.push_back('{wr: w, addr: a, data: d});
    if (exp_rsp) rsp_q.push_back('{data: rdat, hit: rhit});
    @(negedge clk28);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk28);
      if (rsp_valid) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
    @(negedge clk28);
  endtask

  task automatic wait_ioreq(input string name, input int budget);
    for (int i = 0; i < budget && !ioreq; i++) @(negedge clk28);
    check(name, 32'(ioreq), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_io, lat, nrsp, nio;
    int rt[$];

    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_data = '0;
    flush = 1'b0; bus_grant = 1'b0; kd = 5'b10101; tape_in = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    // reset state
    check("rst_ioreq", 32'(ioreq), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_a_reg", 32'(a_reg), 32'd0);
    check("rst_d_reg", 32'(d_reg), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk28);
    @(negedge clk28);
    rst_n = 1'b1;
    @(negedge clk28);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write #7FFD = 0x17: paging latch and end-to-end latency
    bus_grant = 1'b1;
    push(1'b1, 16'h7FFD, 8'h17, 1, 1, 1, 8'h17, 1'b0);
    first_io = -1;
    lat      = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk28);
      if (ioreq && first_io < 0) first_io = i;
      if (rsp_valid) lat = i;
    end
    check("t1_ioreq_rise", 32'(first_io), 32'd3);
    check("t1_rsp_latency", 32'(lat), 32'd13);
    check("t1_rampage", 32'(rampage), 32'd7);
    check("t1_screen", 32'(screen), 32'd0);
    check("t1_rom", 32'(rom), 32'd1);
    @(negedge clk28);

    // Read #00FE with keys 10101, tape high -> claimed, 0xF5
    push(1'b0, 16'h00FE, 8'h00, 1, 1, 1, 8'hF5, 1'b1);
    wait_rsp("t2_rsp_seen", 40);

    // Read #FFFD with nobody answering -> floating bus
    push(1'b0, 16'hFFFD, 8'h00, 1, 1, 1, 8'hFF, 1'b0);
    wait_rsp("t3_rsp_seen", 40);

    // Fill the queue with grant low, fifth push refused, then drain in order
    bus_grant = 1'b0;
    push(1'b1, 16'h00FE, 8'h02, 1, 1, 1, 8'h02, 1'b0);
    push(1'b0, 16'h00FE, 8'h00, 1, 1, 1, 8'hF5, 1'b1);
    push(1'b1, 16'h7FFD, 8'h10, 1, 1, 1, 8'h10, 1'b0);
    push(1'b0, 16'hFFFD, 8'h00, 1, 1, 1, 8'hFF, 1'b0);
    push(1'b1, 16'h1FFD, 8'h04, 0, 0, 0, 8'h00, 1'b0);
    check("full_busy_no_grant", 32'(busy), 32'd0);
    bus_grant = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk28);
      if (rsp_valid) rt.push_back(i);
    end
    check("full_rsp_count", 32'(rt.size()), 32'd4);
    for (int k = 0; k < rt.size() && k < 4; k++)
      check("full_rsp_time", 32'(rt[k]), 32'(13 + 13 * k));
    check("full_rampage", 32'(rampage), 32'd0);

    // Flush during the first cycle's ACTIVE: only that cycle completes
    push(1'b1, 16'h00FE, 8'h05, 1, 1, 1, 8'h05, 1'b0);
    push(1'b1, 16'h7FFD, 8'h07, 1, 0, 0, 8'h00, 1'b0);
    push(1'b0, 16'h00FE, 8'h00, 1, 0, 0, 8'h00, 1'b0);
    wait_ioreq("flush_ioreq_seen", 20);
    flush = 1'b1;
    @(negedge clk28);
    flush = 1'b0;
    nrsp = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk28);
      if (rsp_valid) nrsp++;
    end
    check("flush_rsp_count", 32'(nrsp), 32'd1);
    check("flush_busy_after", 32'(busy), 32'd0);
    check("flush_rampage_kept", 32'(rampage), 32'd0);

    // Reset in the middle of ACTIVE: bus released at once, queue emptied, no response
    push(1'b0, 16'h00FE, 8'h00, 1, 1, 0, 8'h00, 1'b0);
    push(1'b1, 16'h7FFD, 8'h03, 1, 0, 0, 8'h00, 1'b0);
    wait_ioreq("rst_mid_ioreq_seen", 20);
    repeat (3) @(negedge clk28);
    @(posedge clk28);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ioreq", 32'(ioreq), 32'd0);
    check("rst_mid_rd", 32'(rd), 32'd0);
    check("rst_mid_wr", 32'(wr), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk28);
    @(negedge clk28);
    rst_n = 1'b1;
    nrsp = 0;
    nio  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk28);
      if (rsp_valid) nrsp++;
      if (ioreq) nio++;
    end
    check("rst_mid_no_rsp", 32'(nrsp), 32'd0);
    check("rst_mid_no_bus", 32'(nio), 32'd0);
    check("rst_mid_busy_after", 32'(busy), 32'd0);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);

    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
